// File: rtl/wb_arbiter_if.sv
// wb_arbiter_if: shared Wishbone bus bundle between N masters, the arbiter and one slave
interface wb_arbiter_if #(
  parameter int NUM_MASTERS   = 2,
  parameter int WB_BUS_WIDTH  = 16,
  parameter int WB_ADDR_WIDTH = 32
);
  localparam int SW = WB_BUS_WIDTH / 8;
  logic [NUM_MASTERS-1:0]               m_cyc_i;
  logic [NUM_MASTERS-1:0]               m_stb_i;
  logic [NUM_MASTERS-1:0]               m_we_i;
  logic [NUM_MASTERS*WB_ADDR_WIDTH-1:0] m_addr_i;
  logic [NUM_MASTERS*WB_BUS_WIDTH-1:0]  m_data_i;
  logic [NUM_MASTERS*SW-1:0]            m_sel_i;
  logic [WB_BUS_WIDTH-1:0]              m_data_o;
  logic [NUM_MASTERS-1:0]               m_ack_o;
  logic [NUM_MASTERS-1:0]               m_err_o;
  logic [NUM_MASTERS-1:0]               m_stall_o;
  logic                                 s_cyc_o;
  logic                                 s_stb_o;
  logic                                 s_we_o;
  logic [WB_ADDR_WIDTH-1:0]             s_addr_o;
  logic [WB_BUS_WIDTH-1:0]              s_data_o;
  logic [SW-1:0]                        s_sel_o;
  logic [WB_BUS_WIDTH-1:0]              s_data_i;
  logic                                 s_ack_i;
  logic                                 s_err_i;
  logic                                 s_stall_i;
  // arbiter's face toward the masters
  modport slave (
    input  m_cyc_i, m_stb_i, m_we_i, m_addr_i, m_data_i, m_sel_i,
    output m_data_o, m_ack_o, m_err_o, m_stall_o
  );
  // arbiter's face toward the shared slave
  modport master (
    output s_cyc_o, s_stb_o, s_we_o, s_addr_o, s_data_o, s_sel_o,
    input  s_data_i, s_ack_i, s_err_i, s_stall_i
  );
endinterface

// File: rtl/wb_arbiter.sv
// wb_arbiter: round-robin arbiter sharing one Wishbone slave among NUM_MASTERS masters;
// define WB_ARBITER_TIMEOUT_EN to add an ack watchdog that aborts a hung owner
module wb_arbiter #(
  parameter int NUM_MASTERS   = 2,
  parameter int WB_BUS_WIDTH  = 16,
  parameter int WB_ADDR_WIDTH = 32
`ifdef WB_ARBITER_TIMEOUT_EN
  , parameter int TIMEOUT     = 255
`endif
) (
  input  logic                   wb_clk_i,
  input  logic                   wb_reset_n_i,
  wb_arbiter_if.slave            m_bus,
  wb_arbiter_if.master           s_bus,
  output logic [NUM_MASTERS-1:0] grant_o
);
  localparam int NM = NUM_MASTERS;
  localparam int IW = $clog2(NUM_MASTERS);
  localparam int SW = WB_BUS_WIDTH / 8;
  logic          owner_valid_q, owner_valid_d;
  logic [IW-1:0] owner_q, owner_d, last_q, last_d, cand;
  logic [NM-1:0] req;
  logic          arb, abort;
  assign grant_o = owner_valid_q ? NM'(1) << owner_q : '0;
  // an aborted owner is treated as not requesting so it cannot win again at once
  assign req = m_bus.m_cyc_i & ~(abort ? grant_o : '0);
  assign arb = !owner_valid_q || !req[owner_q];
  // round-robin search from last+1; descending loop leaves the nearest requester
  always_comb begin
    owner_valid_d = owner_valid_q;
    owner_d       = owner_q;
    last_d        = last_q;
    cand          = '0;
    if (arb) begin
      owner_valid_d = 1'b0;
      for (int i = NM; i >= 1; i--) begin
        cand = IW'((int'(last_q) + i) % NM);
        if (req[cand]) begin
          owner_valid_d = 1'b1;
          owner_d       = cand;
          last_d        = cand;
        end
      end
    end
  end
  // ownership state; reset points last at the top master so master 0 wins first
  always_ff @(posedge wb_clk_i or negedge wb_reset_n_i) begin
    if (!wb_reset_n_i) begin
      owner_valid_q <= 1'b0;
      owner_q       <= '0;
      last_q        <= IW'(NM - 1);
    end else begin
      owner_valid_q <= owner_valid_d;
      owner_q       <= owner_d;
      last_q        <= last_d;
    end
  end
`ifdef WB_ARBITER_TIMEOUT_EN
  logic        abort_q, abort_d, inc;
  logic [15:0] cnt_q, cnt_d;
  assign abort = abort_q;
  // count stalled strobe cycles of the current tenure; hitting the limit raises a one-cycle abort
  always_comb begin
    inc     = owner_valid_q && m_bus.m_stb_i[owner_q] && !s_bus.s_ack_i && !s_bus.s_err_i && !abort_q;
    abort_d = inc && !arb && cnt_q == 16'(TIMEOUT - 1);
    cnt_d   = (s_bus.s_ack_i || s_bus.s_err_i || abort_q || abort_d || arb) ? '0 : inc ? cnt_q + 16'd1 : cnt_q;
  end
  // watchdog registers
  always_ff @(posedge wb_clk_i or negedge wb_reset_n_i) begin
    if (!wb_reset_n_i) begin
      cnt_q   <= '0;
      abort_q <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      abort_q <= abort_d;
    end
  end
`else
  assign abort = 1'b0;
`endif
  assign s_bus.s_cyc_o  = owner_valid_q && !abort && m_bus.m_cyc_i[owner_q];
  assign s_bus.s_stb_o  = owner_valid_q && !abort && m_bus.m_stb_i[owner_q];
  assign s_bus.s_we_o   = owner_valid_q && m_bus.m_we_i[owner_q];
  assign s_bus.s_addr_o = owner_valid_q ? m_bus.m_addr_i[int'(owner_q)*WB_ADDR_WIDTH +: WB_ADDR_WIDTH] : '0;
  assign s_bus.s_data_o = owner_valid_q ? m_bus.m_data_i[int'(owner_q)*WB_BUS_WIDTH +: WB_BUS_WIDTH] : '0;
  assign s_bus.s_sel_o  = owner_valid_q ? m_bus.m_sel_i[int'(owner_q)*SW +: SW] : '0;
  assign m_bus.m_data_o  = s_bus.s_data_i;
  assign m_bus.m_ack_o   = grant_o & {NM{s_bus.s_ack_i}};
  assign m_bus.m_err_o   = grant_o & {NM{s_bus.s_err_i | abort}};
  assign m_bus.m_stall_o = ~grant_o | {NM{s_bus.s_stall_i}};
endmodule

// File: tb/tb_wb_arbiter.sv
// tb_wb_arbiter: directed and random checks of wb_arbiter against a round-robin reference model
module tb_wb_arbiter;
  localparam int NM = 4;
  localparam int DW = 16;
  localparam int AW = 32;
  localparam int SW = DW / 8;
`ifdef WB_ARBITER_TIMEOUT_EN
  localparam int TO = 8;
`endif
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;
  wb_arbiter_if #(.NUM_MASTERS(NM), .WB_BUS_WIDTH(DW), .WB_ADDR_WIDTH(AW)) bus ();
  logic [NM-1:0] grant;
  wb_arbiter #(
    .NUM_MASTERS(NM), .WB_BUS_WIDTH(DW), .WB_ADDR_WIDTH(AW)
`ifdef WB_ARBITER_TIMEOUT_EN
    , .TIMEOUT(TO)
`endif
  ) dut (
    .wb_clk_i(clk), .wb_reset_n_i(rst_n), .m_bus(bus), .s_bus(bus), .grant_o(grant)
  );
  logic [NM-1:0] cyc = '0, stb = '0, we = '0;
  logic [AW-1:0] addr [NM];
  logic [DW-1:0] wdat [NM];
  logic [SW-1:0] sel  [NM];
  logic [DW-1:0] sdat = '0;
  logic          sack = 1'b0, serr = 1'b0, sstall = 1'b0;
  always_comb begin
    bus.m_cyc_i   = cyc;
    bus.m_stb_i   = stb;
    bus.m_we_i    = we;
    bus.m_addr_i  = '0;
    bus.m_data_i  = '0;
    bus.m_sel_i   = '0;
    for (int k = 0; k < NM; k++) begin
      bus.m_addr_i[k*AW +: AW] = addr[k];
      bus.m_data_i[k*DW +: DW] = wdat[k];
      bus.m_sel_i[k*SW +: SW]  = sel[k];
    end
    bus.s_data_i  = sdat;
    bus.s_ack_i   = sack;
    bus.s_err_i   = serr;
    bus.s_stall_i = sstall;
  end
  int n_cmp = 0, n_bad = 0;
  int own, last, cnt;
  bit abort;
  task automatic chk(input string t, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    assert (got === exp) else begin
      n_bad++;
      $error("FAIL %s: got %0h expected %0h", t, got, exp);
    end
  endtask
  task automatic model_reset();
    own = -1; last = NM - 1; cnt = 0; abort = 0;
  endtask
  // one rising edge of the reference: optional watchdog, then round-robin pick
  task automatic model_step();
    logic [NM-1:0] req;
    bit arb, hit, inc;
    if (!rst_n) return;
    req = cyc;
    if (abort && own >= 0) req[own] = 1'b0;
    arb = own < 0 || !req[own];
    hit = 0;
    inc = own >= 0 && stb[own] && !sack && !serr && !abort;
`ifdef WB_ARBITER_TIMEOUT_EN
    hit = inc && !arb && cnt + 1 == TO;
    cnt = (sack || serr || abort || hit || arb) ? 0 : inc ? cnt + 1 : cnt;
`endif
    abort = hit;
    if (arb) begin
      own = -1;
      for (int i = 1; i <= NM; i++) begin
        if (req[(last + i) % NM]) begin
          own  = (last + i) % NM;
          last = own;
          break;
        end
      end
    end
  endtask
  task automatic check_all(input string t);
    logic [NM-1:0] eg, es;
    bit on;
    on = own >= 0;
    eg = on ? NM'(1) << own : '0;
    es = '1;
    if (on) es[own] = sstall;
    chk({t, ":grant"}, grant, eg);
    chk({t, ":ack"}, bus.m_ack_o, sack ? eg : '0);
    chk({t, ":err"}, bus.m_err_o, (serr || abort) ? eg : '0);
    chk({t, ":stall"}, bus.m_stall_o, es);
    chk({t, ":mdata"}, bus.m_data_o, sdat);
    chk({t, ":scyc"}, bus.s_cyc_o, on && !abort ? cyc[own] : 1'b0);
    chk({t, ":sstb"}, bus.s_stb_o, on && !abort ? stb[own] : 1'b0);
    chk({t, ":swe"}, bus.s_we_o, on ? we[own] : 1'b0);
    chk({t, ":saddr"}, bus.s_addr_o, on ? addr[own] : '0);
    chk({t, ":sdata"}, bus.s_data_o, on ? wdat[own] : '0);
    chk({t, ":ssel"}, bus.s_sel_o, on ? sel[own] : '0);
  endtask
  task automatic step();
    @(posedge clk);
    model_step();
    #1;
  endtask
  initial begin
    int f0, f1, n0;
    for (int k = 0; k < NM; k++) begin
      addr[k] = AW'(32'h1000 * (k + 1));
      wdat[k] = DW'(16'h1111 * (k + 1));
      sel[k]  = SW'(k + 1);
    end
    model_reset();
    cyc = 4'b0011; stb = 4'b0011;
    #2 check_all("in_rst");
    @(negedge clk);
    rst_n = 1'b1;
    #1 check_all("released");
    step();
    #1 check_all("first_grant");
    chk("first_grant_lit", grant, 4'b0001);
    chk("first_addr_lit", bus.s_addr_o, 32'h0000_1000);
    sdat = 16'hBEEF; sack = 1'b1;
    for (int i = 0; i < 3; i++) begin
      if (i == 2) cyc[0] = 1'b0;
      #1 check_all("own0");
      chk("m1_no_ack", bus.m_ack_o[1], 1'b0);
      chk("m1_stalled", bus.m_stall_o[1], 1'b1);
      chk("beef_bcast", bus.m_data_o, 16'hBEEF);
      step();
    end
    sack = 1'b0;
    #1 check_all("handover");
    chk("handover_lit", grant, 4'b0010);
    chk("handover_cyc", bus.s_cyc_o, 1'b1);
    #1 rst_n = 1'b0;
    model_reset();
    #1 chk("midrst_cyc", bus.s_cyc_o, 1'b0);
    chk("midrst_grant", grant, 4'b0000);
    check_all("midrst");
    @(negedge clk);
    rst_n = 1'b1;
    cyc = '1; stb = '1; sack = 1'b1;
    step();
    for (int n = 0; n < 5; n++) begin
      cyc = '1;
      cyc[n % NM] = 1'b0;
      #1 check_all("rot");
      chk("rot_order", grant, NM'(1) << (n % NM));
      step();
    end
    for (int c = 0; c < 300; c++) begin
      for (int k = 0; k < NM; k++) begin
        if ($urandom_range(3) == 0) cyc[k] = ~cyc[k];
        addr[k] = AW'($urandom);
        wdat[k] = DW'($urandom);
        sel[k]  = SW'($urandom);
      end
      stb    = NM'($urandom);
      we     = NM'($urandom);
      sdat   = DW'($urandom);
      sack   = 1'($urandom_range(1));
      serr   = $urandom_range(7) == 0;
      sstall = 1'($urandom_range(1));
      #1 check_all("rnd");
      step();
    end
`ifdef WB_ARBITER_TIMEOUT_EN
    rst_n = 1'b0;
    model_reset();
    cyc = 4'b0011; stb = 4'b0011; sack = 1'b0; serr = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    step();
    f0 = 0; f1 = 0; n0 = 0;
    for (int t = 1; t <= 20; t++) begin
      #1 check_all("tmo");
      if (bus.m_err_o[0] && t < 18) begin
        n0++;
        if (f0 == 0) f0 = t;
      end
      if (bus.m_err_o[1] && f1 == 0) f1 = t;
      step();
    end
    chk("tmo_first_cycle", 64'(f0), 64'd9);
    chk("tmo_single_pulse", 64'(n0), 64'd1);
    chk("tmo_restart", 64'(f1), 64'd18);
`else
    f0 = 0; f1 = 0; n0 = 0;
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
